ats21_client_arbiter: RTL and testbench

- Shares the single ATS21 command interface (req/ctrlA/ctrlB -> ready/stat) between two independent clients, A and B.
- Arbitrates round-robin, latches the winning command, and issues it to the ATS21 as a one-cycle request.
- Waits for the device's ready, with a timeout, then returns status to the originating client only.
- Sits between the client-side control logic and the ATS21 instance.

---
 rtl/ats21_client_arbiter.sv | 132 +++++++++++++
 tb/tb_ats21_client_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ats21_client_arbiter.sv
// Two-client round-robin arbiter in front of the ATS21 command interface.
// The winning command is latched, issued as a one-cycle dev_req, and the
// device ready (or a timeout) is returned as a one-cycle done to that client.
module ats21_client_arbiter #(
   parameter int CTRL_W  = 16,
   parameter int TIMEOUT = 64,
   parameter int TMR_W   = $clog2(TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic [CTRL_W-1:0] a_ctrlA,
   input  logic [CTRL_W-1:0] a_ctrlB,
   output logic              a_done,
   output logic [1:0]        a_stat,
   output logic              a_err,
   input  logic              b_req,
   input  logic [CTRL_W-1:0] b_ctrlA,
   input  logic [CTRL_W-1:0] b_ctrlB,
   output logic              b_done,
   output logic [1:0]        b_stat,
   output logic              b_err,
   output logic              dev_req,
   output logic [CTRL_W-1:0] dev_ctrlA,
   output logic [CTRL_W-1:0] dev_ctrlB,
   input  logic              dev_ready,
   input  logic [1:0]        dev_stat,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              last_grant;   // 0 = client A, 1 = client B
   logic              winner;       // 0 = client A, 1 = client B
   logic [CTRL_W-1:0] cmd_a;
   logic [CTRL_W-1:0] cmd_b;
   logic [TMR_W-1:0]  timer;
   logic [1:0]        stat_r;
   logic              err_r;
   logic              grant_vld;
   logic              grant_b;
   logic              timeout_hit;
   logic              resp_a;
   logic              resp_b;

   // Timer increment that sticks at all-ones instead of wrapping.
   function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
      return (v == {TMR_W{1'b1}}) ? v : v + TMR_W'(1);
   endfunction

   // Round-robin pick: a lone requester wins; on a tie the client that did
   // not win last time gets the grant.
   always_comb begin
      grant_vld   = a_req | b_req;
      grant_b     = b_req & (~a_req | ~last_grant);
      timeout_hit = (timer == TMR_W'(TIMEOUT - 1));
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM next-state logic; dev_ready is only looked at while in WAIT.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_vld) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (dev_ready || timeout_hit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Command latch, wait timer, response capture and round-robin history.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= 1'b1;
         winner     <= 1'b0;
         cmd_a      <= '0;
         cmd_b      <= '0;
         timer      <= '0;
         stat_r     <= 2'b00;
         err_r      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  winner <= grant_b;
                  cmd_a  <= grant_b ? b_ctrlA : a_ctrlA;
                  cmd_b  <= grant_b ? b_ctrlB : a_ctrlB;
               end
            end
            ISSUE: timer <= '0;
            WAIT: begin
               if (dev_ready) begin
                  stat_r <= dev_stat;
                  err_r  <= 1'b0;
               end else if (timeout_hit) begin
                  stat_r <= 2'b00;
                  err_r  <= 1'b1;
               end else begin
                  timer <= sat_inc(timer);
               end
            end
            RESP: last_grant <= winner;
            default: ;
         endcase
      end
   end

   // Outputs decode from state only; responses reach the originating client alone.
   always_comb begin
      resp_a    = (state == RESP) & ~winner;
      resp_b    = (state == RESP) & winner;
      dev_req   = (state == ISSUE);
      dev_ctrlA = cmd_a;
      dev_ctrlB = cmd_b;
      busy      = (state != IDLE);
      a_done    = resp_a;
      a_stat    = resp_a ? stat_r : 2'b00;
      a_err     = resp_a & err_r;
      b_done    = resp_b;
      b_stat    = resp_b ? stat_r : 2'b00;
      b_err     = resp_b & err_r;
   end

endmodule

// File: tb/tb_ats21_client_arbiter.sv
// Directed bench for ats21_client_arbiter: a cycle table for the basic
// transaction plus ignored-ready cases, then hand sequences for alternation,
// timeout, input changes during WAIT and asynchronous reset.
module tb_ats21_client_arbiter;

   localparam int CW = 16;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          a_req = 1'b0, b_req = 1'b0;
   logic [CW-1:0] a_ctrlA = '0, a_ctrlB = '0, b_ctrlA = '0, b_ctrlB = '0;
   logic          a_done, a_err, b_done, b_err;
   logic [1:0]    a_stat, b_stat;
   logic          dev_req, busy;
   logic [CW-1:0] dev_ctrlA, dev_ctrlB;
   logic          dev_ready = 1'b0;
   logic [1:0]    dev_stat = 2'b00;

   int tests = 0;
   int fails = 0;

   ats21_client_arbiter #(.CTRL_W(CW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_ctrlA(a_ctrlA), .a_ctrlB(a_ctrlB),
      .a_done(a_done), .a_stat(a_stat), .a_err(a_err),
      .b_req(b_req), .b_ctrlA(b_ctrlA), .b_ctrlB(b_ctrlB),
      .b_done(b_done), .b_stat(b_stat), .b_err(b_err),
      .dev_req(dev_req), .dev_ctrlA(dev_ctrlA), .dev_ctrlB(dev_ctrlB),
      .dev_ready(dev_ready), .dev_stat(dev_stat), .busy(busy)
   );

   always #5 clk = ~clk;

   // {dev_req, dev_ctrlA, dev_ctrlB, a_done, a_stat, a_err, b_done, b_stat, b_err, busy}
   function automatic logic [41:0] ov(input logic dr, input logic [15:0] ca, input logic [15:0] cb,
                                      input logic ad, input logic [1:0] as, input logic ae,
                                      input logic bd, input logic [1:0] bs, input logic be,
                                      input logic bz);
      return {dr, ca, cb, ad, as, ae, bd, bs, be, bz};
   endfunction

   function automatic logic [41:0] outs();
      return {dev_req, dev_ctrlA, dev_ctrlB, a_done, a_stat, a_err, b_done, b_stat, b_err, busy};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      a_req = 1'b0; b_req = 1'b0; dev_ready = 1'b0; dev_stat = 2'b00;
      tick();
      tick();
      chk("reset_outputs", 64'(outs()), 64'(42'd0));
      reset = 1'b0;
   endtask

   typedef struct {
      logic        a_req;
      logic [15:0] a_ca;
      logic [15:0] a_cb;
      logic        b_req;
      logic [15:0] b_ca;
      logic [15:0] b_cb;
      logic        rdy;
      logic [1:0]  st;
      logic [41:0] exp;
   } vec_t;

   vec_t vt[13];

   initial begin
      int n;
      logic saw_req;
      logic wb;

      // Each row is one clock cycle: inputs held for it and outputs seen in it.
      //                a_req  a_ctrlA   a_ctrlB   b_req  b_ctrlA   b_ctrlB   rdy   st     expected outputs
      vt[0]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 2'b11, ov(0, 16'h0000, 16'h0000, 0, 2'b00, 0, 0, 2'b00, 0, 0)};
      vt[1]  = '{1'b1, 16'h1234, 16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b00, ov(0, 16'h0000, 16'h0000, 0, 2'b00, 0, 0, 2'b00, 0, 0)};
      vt[2]  = '{1'b1, 16'h1234, 16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b00, ov(1, 16'h1234, 16'h0010, 0, 2'b00, 0, 0, 2'b00, 0, 1)};
      vt[3]  = '{1'b1, 16'h1234, 16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b1, 2'b01, ov(0, 16'h1234, 16'h0010, 0, 2'b00, 0, 0, 2'b00, 0, 1)};
      vt[4]  = '{1'b1, 16'h1234, 16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b00, ov(0, 16'h1234, 16'h0010, 1, 2'b01, 0, 0, 2'b00, 0, 1)};
      vt[5]  = '{1'b0, 16'h1234, 16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b00, ov(0, 16'h1234, 16'h0010, 0, 2'b00, 0, 0, 2'b00, 0, 0)};
      vt[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b00, ov(0, 16'h1234, 16'h0010, 0, 2'b00, 0, 0, 2'b00, 0, 0)};
      vt[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 16'h0001, 1'b1, 2'b11, ov(0, 16'h1234, 16'h0010, 0, 2'b00, 0, 0, 2'b00, 0, 0)};
      vt[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 16'h0001, 1'b1, 2'b11, ov(1, 16'hBEEF, 16'h0001, 0, 2'b00, 0, 0, 2'b00, 0, 1)};
      vt[9]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 16'h0001, 1'b0, 2'b00, ov(0, 16'hBEEF, 16'h0001, 0, 2'b00, 0, 0, 2'b00, 0, 1)};
      vt[10] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 16'h0001, 1'b1, 2'b10, ov(0, 16'hBEEF, 16'h0001, 0, 2'b00, 0, 0, 2'b00, 0, 1)};
      vt[11] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 16'h0001, 1'b1, 2'b11, ov(0, 16'hBEEF, 16'h0001, 0, 2'b00, 0, 1, 2'b10, 0, 1)};
      vt[12] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 2'b11, ov(0, 16'hBEEF, 16'h0001, 0, 2'b00, 0, 0, 2'b00, 0, 0)};

      do_reset();

      // Single command from A, then B with dev_ready pulsed in IDLE/ISSUE/RESP
      for (int i = 0; i < 13; i++) begin
         a_req = vt[i].a_req; a_ctrlA = vt[i].a_ca; a_ctrlB = vt[i].a_cb;
         b_req = vt[i].b_req; b_ctrlA = vt[i].b_ca; b_ctrlB = vt[i].b_cb;
         dev_ready = vt[i].rdy; dev_stat = vt[i].st;
         chk($sformatf("table_row%0d", i), 64'(outs()), 64'(vt[i].exp));
         tick();
      end
      dev_ready = 1'b0;

      // Both clients requesting continuously: grants must go A,B,A,B
      do_reset();
      a_ctrlA = 16'hA0A1; a_ctrlB = 16'hA0A2;
      b_ctrlA = 16'hB0B1; b_ctrlB = 16'hB0B2;
      a_req = 1'b1; b_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wb = k[0];
         chk($sformatf("alt%0d_idle_busy", k), 64'(busy), 64'(0));
         tick();
         chk($sformatf("alt%0d_dev_req", k), 64'(dev_req), 64'(1));
         chk($sformatf("alt%0d_ctrl", k), 64'({dev_ctrlA, dev_ctrlB}),
             wb ? 64'({16'hB0B1, 16'hB0B2}) : 64'({16'hA0A1, 16'hA0A2}));
         tick();
         tick();
         dev_ready = 1'b1; dev_stat = 2'(k);
         tick();
         dev_ready = 1'b0;
         chk($sformatf("alt%0d_resp", k), 64'({a_done, a_stat, b_done, b_stat}),
             wb ? 64'({1'b0, 2'b00, 1'b1, 2'(k)}) : 64'({1'b1, 2'(k), 1'b0, 2'b00}));
         tick();
      end
      a_req = 1'b0; b_req = 1'b0;
      tick();

      // Timeout: B requests and the device never answers
      b_req = 1'b1; b_ctrlA = 16'h7777; b_ctrlB = 16'h0003;
      tick();
      chk("to_dev_req", 64'(dev_req), 64'(1));
      tick();
      n = 0;
      saw_req = 1'b0;
      while (!b_done && n < 20) begin
         saw_req = saw_req | dev_req;
         tick();
         n++;
      end
      chk("to_latency", 64'(n), 64'(TO));
      chk("to_resp", 64'({b_done, b_stat, b_err, a_done}), 64'({1'b1, 2'b00, 1'b1, 1'b0}));
      b_req = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         saw_req = saw_req | dev_req | busy;
         tick();
      end
      chk("to_no_reissue", 64'(saw_req), 64'(0));

      // Client A changes its command word while the device is busy
      a_req = 1'b1; a_ctrlA = 16'hAAAA; a_ctrlB = 16'h0042;
      tick();
      tick();
      a_ctrlA = 16'h5555;
      tick();
      chk("hold_wait_ctrlA", 64'(dev_ctrlA), 64'(16'hAAAA));
      dev_ready = 1'b1; dev_stat = 2'b11;
      tick();
      dev_ready = 1'b0;
      chk("hold_resp", 64'({dev_ctrlA, a_done, a_stat}), 64'({16'hAAAA, 1'b1, 2'b11}));
      a_req = 1'b0;
      tick();

      // Asynchronous reset in WAIT aborts silently; A wins afterwards if requesting
      b_req = 1'b1; b_ctrlA = 16'hB00B; b_ctrlB = 16'h0B0B;
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      chk("areset_immediate", 64'(outs()), 64'(42'd0));
      tick();
      chk("areset_held", 64'(outs()), 64'(42'd0));
      a_req = 1'b1; a_ctrlA = 16'h0C0C; a_ctrlB = 16'h0D0D;
      reset = 1'b0;
      tick();
      chk("areset_a_first", 64'({dev_req, dev_ctrlA, dev_ctrlB}), 64'({1'b1, 16'h0C0C, 16'h0D0D}));
      tick();
      dev_ready = 1'b1; dev_stat = 2'b01;
      tick();
      dev_ready = 1'b0;
      chk("areset_a_done", 64'({a_done, a_stat, b_done}), 64'({1'b1, 2'b01, 1'b0}));
      a_req = 1'b0;
      tick();
      tick();
      chk("areset_b_next", 64'({dev_req, dev_ctrlA}), 64'({1'b1, 16'hB00B}));
      b_req = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Hard bound on simulation time.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

endmodule
